// File: rtl/sprite_pkg.sv
// Shared types and geometry constants for the sprite motion controllers.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    JUMP = 2'd2,
    FALL = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } dir_e;

  localparam int SPRITE_W = 47;
  localparam int SPRITE_H = 41;
  localparam int BG_W     = 551;
  localparam int BG_H     = 401;

  localparam int NUM_FRAMES_DEF = 6;

  function automatic dir_e decode_dir(input logic left, input logic right);
    if (right && !left) return DIR_RIGHT;
    if (left && !right) return DIR_LEFT;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/anim_frame_seq.sv
// Animation frame sequencer: divides advance pulses by ANIM_DIV and steps a
// modulo-NUM_FRAMES frame index; supports clear, load of a fixed frame, and hold.
module anim_frame_seq #(
  parameter int NUM_FRAMES = 6,
  parameter int ANIM_DIV   = 4,
  parameter int FW         = 3,
  parameter int CW         = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          adv_i,
  input  logic          hold_i,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic [FW-1:0] load_val_i,
  output logic [FW-1:0] frame_o
);

  logic [CW-1:0] cnt_q,   cnt_d;
  logic [FW-1:0] frame_q, frame_d;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    frame_d = frame_q;
    if (clear_i) begin
      cnt_d   = '0;
      frame_d = '0;
    end else if (load_i) begin
      cnt_d   = '0;
      frame_d = load_val_i;
    end else if (adv_i && !hold_i) begin
      if (cnt_q == CW'(ANIM_DIV - 1)) begin
        cnt_d   = '0;
        frame_d = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + FW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  assign frame_o = frame_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame position, walk/jump state and animation select for the player sprite.
// All state advances only on an unfrozen frame_tick so the sprite never tears.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int X_INIT     = 0,
  parameter int X_MAX      = BG_W - SPRITE_W,
  parameter int Y_FLOOR    = BG_H - SPRITE_H - 1,
  parameter int STEP_X     = 2,
  parameter int JUMP_V0    = 12,
  parameter int GRAV       = 1,
  parameter int VMAX       = 12,
  parameter int ANIM_DIV   = 4,
  parameter int NUM_FRAMES = NUM_FRAMES_DEF,
  parameter int JUMP_FRAME = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       frame_tick,
  input  logic       freeze,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  output logic [9:0] x_pos,
  output logic [8:0] y_pos,
  output logic [2:0] frame_sel,
  output logic       facing,
  output logic       airborne,
  output logic       moving
);

  localparam logic signed [10:0] X_MAX_S   = 11'(X_MAX);
  localparam logic signed [10:0] STEP_S    = 11'(STEP_X);
  localparam logic signed [10:0] Y_FLOOR_S = 11'(Y_FLOOR);
  localparam logic signed [6:0]  V0_S      = 7'(JUMP_V0);
  localparam logic signed [6:0]  GRAV_S    = 7'(GRAV);
  localparam logic signed [6:0]  VMAX_S    = 7'(VMAX);

  state_e             state_q,    state_d;
  logic [9:0]         x_q,        x_d;
  logic [8:0]         y_q,        y_d;
  logic signed [5:0]  vy_q,       vy_d;
  logic               facing_q,   facing_d;
  logic               airborne_q, airborne_d;
  logic               moving_q,   moving_d;

  logic               tick;
  dir_e               dir;
  logic               launch;
  logic               in_air;
  logic signed [10:0] x_ext, x_sum, x_clamp;
  logic signed [10:0] y_ext, y_sum, vy_ext;
  logic signed [6:0]  vy_cur, vy_up;

  logic               seq_clear, seq_load;

  assign tick = frame_tick && !freeze;
  assign dir  = decode_dir(key_left, key_right);

  always_comb begin
    x_ext   = {1'b0, x_q};
    x_sum   = x_ext;
    x_clamp = x_ext;
    unique case (dir)
      DIR_RIGHT: x_sum = x_ext + STEP_S;
      DIR_LEFT:  x_sum = x_ext - STEP_S;
      default:   x_sum = x_ext;
    endcase
    if (x_sum < 11'sd0)        x_clamp = '0;
    else if (x_sum > X_MAX_S)  x_clamp = X_MAX_S;
    else                       x_clamp = x_sum;
    x_d = 10'(x_clamp);

    facing_d = facing_q;
    if (dir == DIR_RIGHT)     facing_d = 1'b0;
    else if (dir == DIR_LEFT) facing_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vy_d    = vy_q;
    launch  = 1'b0;
    in_air  = (state_q == JUMP) || (state_q == FALL);

    unique case (state_q)
      IDLE: begin
        if (key_jump)              launch  = 1'b1;
        else if (dir != DIR_NONE)  state_d = WALK;
      end
      WALK: begin
        if (key_jump)              launch  = 1'b1;
        else if (dir == DIR_NONE)  state_d = IDLE;
      end
      default: ;
    endcase

    // A launch applies its first airborne step on the same tick it is taken.
    vy_cur = launch ? -V0_S : {vy_q[5], vy_q};
    vy_ext = {{4{vy_cur[6]}}, vy_cur};
    y_ext  = {2'b00, y_q};
    y_sum  = y_ext + vy_ext;
    vy_up  = vy_cur + GRAV_S;
    if (vy_up > VMAX_S) vy_up = VMAX_S;

    if (launch || in_air) begin
      if (y_sum < 11'sd0) begin
        y_d     = '0;
        vy_d    = '0;
        state_d = FALL;
      end else if (y_sum >= Y_FLOOR_S) begin
        y_d     = 9'(Y_FLOOR);
        vy_d    = '0;
        state_d = (dir == DIR_NONE) ? IDLE : WALK;
      end else begin
        y_d     = 9'(y_sum);
        vy_d    = 6'(vy_up);
        state_d = (vy_up < 7'sd0) ? JUMP : FALL;
      end
    end

    airborne_d = (state_d == JUMP) || (state_d == FALL);
    moving_d   = (state_d == WALK) || (airborne_d && (dir != DIR_NONE));
  end

  // Airborne overrides the animation; otherwise a state change restarts it.
  assign seq_load  = tick && airborne_d;
  assign seq_clear = tick && !airborne_d && (state_d != state_q);

  anim_frame_seq #(
    .NUM_FRAMES (NUM_FRAMES),
    .ANIM_DIV   (ANIM_DIV),
    .FW         (3)
  ) u_anim (
    .clk        (clk),
    .rstn       (rstn),
    .adv_i      (frame_tick),
    .hold_i     (freeze),
    .clear_i    (seq_clear),
    .load_i     (seq_load),
    .load_val_i (3'(JUMP_FRAME)),
    .frame_o    (frame_sel)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      x_q        <= 10'(X_INIT);
      y_q        <= 9'(Y_FLOOR);
      vy_q       <= '0;
      facing_q   <= 1'b0;
      airborne_q <= 1'b0;
      moving_q   <= 1'b0;
    end else if (tick) begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vy_q       <= vy_d;
      facing_q   <= facing_d;
      airborne_q <= airborne_d;
      moving_q   <= moving_d;
    end
  end

  assign x_pos    = x_q;
  assign y_pos    = y_q;
  assign facing   = facing_q;
  assign airborne = airborne_q;
  assign moving   = moving_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: a vector table for ground motion and
// freeze, plus hand-written clamp, jump, landing and mid-air reset sequences.
module tb_sprite_motion_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       frame_tick = 1'b0;
  logic       freeze = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       key_jump = 1'b0;
  logic [9:0] x_pos;
  logic [8:0] y_pos;
  logic [2:0] frame_sel;
  logic       facing;
  logic       airborne;
  logic       moving;

  int checks = 0;
  int errors = 0;

  sprite_motion_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .frame_tick (frame_tick),
    .freeze     (freeze),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_jump   (key_jump),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .frame_sel  (frame_sel),
    .facing     (facing),
    .airborne   (airborne),
    .moving     (moving)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fz;
    logic       kl;
    logic       kr;
    logic       kj;
    logic [9:0] ex;
    logic [8:0] ey;
    logic [2:0] ef;
    logic       efac;
    logic       eair;
    logic       emov;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  int unsigned jump_y [25];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int unsigned ex, input int unsigned ey,
                           input int unsigned ef, input int unsigned efac,
                           input int unsigned eair, input int unsigned emov);
    check({tag, " x_pos"},     x_pos,     ex);
    check({tag, " y_pos"},     y_pos,     ey);
    check({tag, " frame_sel"}, frame_sel, ef);
    check({tag, " facing"},    facing,    efac);
    check({tag, " airborne"},  airborne,  eair);
    check({tag, " moving"},    moving,    emov);
  endtask

  // Entered and left at a falling edge; one idle cycle follows the tick to show outputs hold.
  task automatic do_tick(input logic fz, input logic kl, input logic kr, input logic kj);
    freeze     = fz;
    key_left   = kl;
    key_right  = kr;
    key_jump   = kj;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Idle animation: advances on ticks 4 and 8, no motion.
    vecs[0]  = '{0,0,0,0, 10'd0,   9'd359, 3'd0, 0,0,0};
    vecs[1]  = '{0,0,0,0, 10'd0,   9'd359, 3'd0, 0,0,0};
    vecs[2]  = '{0,0,0,0, 10'd0,   9'd359, 3'd0, 0,0,0};
    vecs[3]  = '{0,0,0,0, 10'd0,   9'd359, 3'd1, 0,0,0};
    vecs[4]  = '{0,0,0,0, 10'd0,   9'd359, 3'd1, 0,0,0};
    vecs[5]  = '{0,0,0,0, 10'd0,   9'd359, 3'd1, 0,0,0};
    vecs[6]  = '{0,0,0,0, 10'd0,   9'd359, 3'd1, 0,0,0};
    vecs[7]  = '{0,0,0,0, 10'd0,   9'd359, 3'd2, 0,0,0};
    // Walk right, turn left, clamp at 0, both keys back to idle.
    vecs[8]  = '{0,0,1,0, 10'd2,   9'd359, 3'd0, 0,0,1};
    vecs[9]  = '{0,0,1,0, 10'd4,   9'd359, 3'd0, 0,0,1};
    vecs[10] = '{0,1,0,0, 10'd2,   9'd359, 3'd0, 1,0,1};
    vecs[11] = '{0,1,0,0, 10'd0,   9'd359, 3'd0, 1,0,1};
    vecs[12] = '{0,1,0,0, 10'd0,   9'd359, 3'd1, 1,0,1};
    vecs[13] = '{0,1,1,0, 10'd0,   9'd359, 3'd0, 1,0,0};
    vecs[14] = '{0,0,0,0, 10'd0,   9'd359, 3'd0, 1,0,0};
    // Frozen ticks with keys held change nothing.
    vecs[15] = '{1,0,1,1, 10'd0,   9'd359, 3'd0, 1,0,0};
    vecs[16] = '{1,0,1,0, 10'd0,   9'd359, 3'd0, 1,0,0};
    vecs[17] = '{1,1,0,1, 10'd0,   9'd359, 3'd0, 1,0,0};
    vecs[18] = '{1,0,0,0, 10'd0,   9'd359, 3'd0, 1,0,0};
    vecs[19] = '{1,0,1,0, 10'd0,   9'd359, 3'd0, 1,0,0};
    // First unfrozen tick resumes.
    vecs[20] = '{0,0,1,0, 10'd2,   9'd359, 3'd0, 0,0,1};
    vecs[21] = '{0,0,1,0, 10'd4,   9'd359, 3'd0, 0,0,1};

    jump_y = '{347, 336, 326, 317, 309, 302, 296, 291, 287, 284, 282, 281, 281,
               282, 284, 287, 291, 296, 302, 309, 317, 326, 336, 347, 359};

    // Reset held for 3 cycles.
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_all("reset", 0, 359, 0, 0, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      do_tick(vecs[i].fz, vecs[i].kl, vecs[i].kr, vecs[i].kj);
      check_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ef,
                vecs[i].efac, vecs[i].eair, vecs[i].emov);
    end

    // Walk right from 4 to 500, then into the right clamp.
    repeat (248) do_tick(0, 0, 1, 0);
    check("preset x_pos", x_pos, 500);
    do_tick(0, 0, 1, 0);
    check("clamp1 x_pos", x_pos, 502);
    do_tick(0, 0, 1, 0);
    check("clamp2 x_pos", x_pos, 504);
    do_tick(0, 0, 1, 0);
    check("clamp3 x_pos", x_pos, 504);
    check("clamp3 facing", facing, 0);
    check("clamp3 moving", moving, 1);
    do_tick(0, 1, 1, 0);
    check_all("both_keys", 504, 359, 0, 0, 0, 0);

    // Single-tick jump press, released for the rest of the arc.
    for (int t = 1; t <= 25; t++) begin
      do_tick(0, 0, 0, (t == 1));
      check_all($sformatf("jump1 t%0d", t), 504, jump_y[t-1],
                (t < 25) ? 5 : 0, 0, (t < 25), 0);
    end

    // Jump held with left: lands walking, re-launches on the following tick.
    for (int t = 1; t <= 25; t++) begin
      do_tick(0, 1, 0, 1);
      check_all($sformatf("jump2 t%0d", t), 504 - 2 * t, jump_y[t-1],
                (t < 25) ? 5 : 0, 1, (t < 25), 1);
    end
    do_tick(0, 1, 0, 1);
    check_all("relaunch", 452, 347, 5, 1, 1, 1);

    // Coast to tick 6 of this jump with no keys.
    repeat (5) do_tick(0, 0, 0, 0);
    check_all("midair t6", 452, 302, 5, 1, 1, 0);

    // Reset coinciding with a tick and a held jump key.
    rstn       = 1'b0;
    frame_tick = 1'b1;
    key_jump   = 1'b1;
    @(negedge clk);
    rstn       = 1'b1;
    frame_tick = 1'b0;
    key_jump   = 1'b0;
    @(negedge clk);
    check_all("reset_midair", 0, 359, 0, 0, 0, 0);
    do_tick(0, 0, 0, 0);
    check_all("post_reset idle", 0, 359, 0, 0, 0, 0);
    do_tick(0, 0, 0, 1);
    check_all("post_reset jump", 0, 347, 5, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
